pixel_stream_source: RTL
========================

Name: pixel_stream_source

Overview:
Parametrised successor to the fixed-size pixel iterator that feeds the Qsys video streaming sink from the multi_solver read port. It walks a WIDTH x HEIGHT frame in raster order and issues interleaved solver reads (pixel p -> solver p mod NUM_SOLVERS, address p div NUM_SOLVERS). It absorbs the solver read latency internally with a credit-limited output FIFO, so Avalon-ST ready backpressure is honoured exactly; the external hand-built delay chain is no longer needed. It adds a per-frame colour mode, a run/stop control and a frame counter.

Parameters:
NUM_SOLVERS, 29, number of interleaved solver RAMs (>=1)
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame
ID_W, 6, solver_id width (2^ID_W >= NUM_SOLVERS)
ADDR_W, 19, solver_addr width (holds ceil(WIDTH*HEIGHT/NUM_SOLVERS)-1)
RD_LATENCY, 2, clocks from rd address to rd_data valid (>=1)
FIFO_DEPTH, 4, output FIFO entries (>= RD_LATENCY+1; power of two)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = start/continue frames; 0 = finish current frame, then idle
color_mode  in  2  0 replicate {d,d}; 1 inverted ~{d,d}; 2 solver-id debug {id[3:0],id[3:0]}; 3 black 8'h00
solver_id  out  ID_W  read solver select
solver_addr  out  ADDR_W  read address within solver
rd_data  in  4  solver data, valid RD_LATENCY clocks after the address
out_data  out  8  stream pixel data
out_valid  out  1  Avalon-ST valid
out_ready  in  1  Avalon-ST ready (sink may hold ready low any number of cycles)
out_sop  out  1  start of packet, first pixel of frame
out_eop  out  1  end of packet, last pixel of frame
busy  out  1  frame in progress (issuing or FIFO/pipeline non-empty)
frame_count  out  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async): all counters 0, state IDLE, FIFO empty, in-flight count 0; out_valid=0, out_sop=0, out_eop=0, out_data=0, solver_id=0, solver_addr=0, busy=0, frame_count=0.
- FSM: IDLE -> ISSUE when run=1 (latch color_mode into frame_mode, stable for whole frame). ISSUE -> DRAIN after issuing pixel WIDTH*HEIGHT-1. DRAIN -> IDLE when FIFO empty and nothing in flight; frame_count++ on that cycle (a 1-cycle frame_done condition). IDLE with run still 1 restarts on the next cycle.
- Issue: one read per clock when state=ISSUE and (fifo_count + in_flight) < FIFO_DEPTH. Counters: id increments, wraps NUM_SOLVERS-1 -> 0 with addr+1; x/y counters track sop (p=0) and eop (p=WIDTH*HEIGHT-1). No division or multiplication in RTL. solver_id/solver_addr hold their value when not issuing.
- Sideband shift register of depth RD_LATENCY carries {valid, sop, eop, id[3:0]}; at its tail rd_data and sideband are mapped through frame_mode and pushed into the FIFO. The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error (assertion).
- Output: out_valid = FIFO non-empty; out_data/out_sop/out_eop are the FIFO head. Pop iff out_valid && out_ready. Head fields stay stable while valid && !ready.
- Simultaneous push and pop: both occur, count unchanged. Push into empty FIFO: visible on out_valid the next clock.
- Throughput: with out_ready held at 1, one pixel per clock sustained; first out_valid RD_LATENCY+1 clocks after leaving IDLE.
- run falling mid-frame: frame completes normally, including eop. color_mode changes mid-frame are ignored until the next frame.
- busy = (state != IDLE).

Test Plan:
- WIDTH=4, HEIGHT=3, NUM_SOLVERS=5, RD_LATENCY=2, ready=1, run pulsed 1 clock: (id,addr) sequence (0,0)(1,0)..(4,0)(0,1)..(4,1)(0,2)(1,2); 12 beats; sop on beat 0 only, eop on beat 11 only; frame_count 0->1; busy then 0.
- Same config, solver model returns rd_data=id+addr, mode 0: beat 6 (id 1, addr 1) -> out_data 8'h22; mode 1 -> 8'hDD; mode 2 -> 8'h11; mode 3 -> 8'h00.
- Random out_ready (~50%) over 3 back-to-back frames (run=1): 36 beats, no loss or duplication, in-order, head stable while stalled, no FIFO overflow assertion, frame_count=3.
- out_ready held 0 for 20 clocks from frame start: issue stops once fifo_count+in_flight=FIFO_DEPTH (4); on ready=1 stream resumes with pixel 0 unchanged.
- color_mode toggled 0->1 at beat 5: all 12 beats of that frame use mode 0; next frame uses mode 1.
- reset asserted at beat 7 mid-frame: outputs go to reset values immediately (asynchronously); after release with run=1, next beat is pixel 0 with sop=1, frame_count=0.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Raster pixel walker that reads interleaved solver RAMs and
// emits an Avalon-ST pixel stream with sop/eop and backpressure.
//
// Ports:
//   clock, reset      : system clock, async active-high reset
//   run               : 1 = start/continue frames, 0 = idle after frame
//   color_mode        : per-frame pixel mapping, latched at frame start
//   solver_id/addr    : read select and address into the solver RAMs
//   rd_data           : solver data, RD_LATENCY clocks after address
//   out_data/valid/ready/sop/eop : Avalon-ST source
//   busy              : frame in progress
//   frame_count       : completed frames (wraps)
module pixel_stream_source #(
  parameter int NUM_SOLVERS = 29,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int ID_W        = 6,
  parameter int ADDR_W      = 19,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [1:0]        color_mode,
  output logic [ID_W-1:0]   solver_id,
  output logic [ADDR_W-1:0] solver_addr,
  input  logic [3:0]        rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int L  = RD_LATENCY;

  localparam logic [XW-1:0]   X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_SOLVERS - 1);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [ID_W-1:0]   id_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        frame_mode;

  logic sop_now;
  logic eop_now;
  logic credit;
  logic issue;
  logic start;
  logic frame_done;

  logic [L-1:0] sb_v;
  logic [L-1:0] sb_sop;
  logic [L-1:0] sb_eop;
  logic [3:0]   sb_id [L];

  logic [CW-1:0] in_flight;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [9:0]    fifo_mem [FIFO_DEPTH];

  logic       push;
  logic       pop;
  logic [3:0] tail_id;
  logic [7:0] map_data;

  assign sop_now = (x_cnt == '0) && (y_cnt == '0);
  assign eop_now = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  // Reads already issued but not yet in the FIFO still own an
  // entry, so the FIFO can never be asked to take more than it has.
  assign credit = ({1'b0, fifo_count} + {1'b0, in_flight}) < CREDITS;

  assign push = sb_v[L-1];
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) begin
          start    = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (eop_now) begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_count == '0 && in_flight == '0) begin
          frame_done = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters rewind at frame start rather than after the last
  // pixel, so the read address holds once the frame is issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      id_cnt     <= '0;
      addr_cnt   <= '0;
      frame_mode <= 2'd0;
    end else if (start) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      id_cnt     <= '0;
      addr_cnt   <= '0;
      frame_mode <= color_mode;
    end else if (issue && !eop_now) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (id_cnt == ID_LAST) begin
        id_cnt   <= '0;
        addr_cnt <= addr_cnt + 1'b1;
      end else begin
        id_cnt <= id_cnt + 1'b1;
      end
    end
  end

  assign solver_id   = id_cnt;
  assign solver_addr = addr_cnt;

  // Sideband travels alongside the RAM read so the tail stage
  // lines up with rd_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_v   <= '0;
      sb_sop <= '0;
      sb_eop <= '0;
      for (int k = 0; k < L; k++) begin
        sb_id[k] <= 4'd0;
      end
    end else begin
      sb_v[0]   <= issue;
      sb_sop[0] <= sop_now;
      sb_eop[0] <= eop_now;
      sb_id[0]  <= 4'(id_cnt);
      for (int k = 1; k < L; k++) begin
        sb_v[k]   <= sb_v[k-1];
        sb_sop[k] <= sb_sop[k-1];
        sb_eop[k] <= sb_eop[k-1];
        sb_id[k]  <= sb_id[k-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight <= '0;
    end else if (issue && !push) begin
      in_flight <= in_flight + 1'b1;
    end else if (!issue && push) begin
      in_flight <= in_flight - 1'b1;
    end
  end

  assign tail_id = sb_id[L-1];

  always_comb begin
    map_data = 8'h00;
    unique case (frame_mode)
      2'd0: map_data = {rd_data, rd_data};
      2'd1: map_data = ~{rd_data, rd_data};
      2'd2: map_data = {tail_id, tail_id};
      2'd3: map_data = 8'h00;
      default: map_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem[k] <= 10'd0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {sb_sop[L-1], sb_eop[L-1], map_data};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_count <= '0;
    end else if (push && !pop) begin
      fifo_count <= fifo_count + 1'b1;
    end else if (pop && !push) begin
      fifo_count <= fifo_count - 1'b1;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign {out_sop, out_eop, out_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign busy = (state != S_IDLE);

  fifo_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    push |-> (fifo_count < CW'(FIFO_DEPTH))
  );

endmodule
